// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding
// and the default PC / return-stack sizing.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int PC_W_DEFAULT      = 11;
  localparam int STK_DEPTH_DEFAULT = 16;

endpackage : pc_pkg

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: resolves stall/ret/call/jump/skip into the next
// fetch address and drives the strobes for an external return stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int STK_DEPTH = STK_DEPTH_DEFAULT,
  localparam int DW       = $clog2(STK_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic            skip,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] stack_out,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            push,
  output logic            pop,
  output logic [PC_W-1:0] stack_in,
  output logic [DW-1:0]   depth,
  output logic            halted,
  output logic            err_ovf,
  output logic            err_unf
);

  localparam logic [DW-1:0] DEPTH_FULL = DW'(STK_DEPTH);

  pc_state_t       r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [DW-1:0]   r_depth, w_depth_next;
  logic            r_halted, r_err_ovf, r_err_unf;
  logic            w_set_ovf, w_set_unf;
  logic            w_push, w_pop, w_fetch_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= BOOT;
      r_pc      <= '0;
      r_depth   <= '0;
      r_halted  <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_depth   <= w_depth_next;
      r_halted  <= r_halted | (w_state_next == HALT);
      r_err_ovf <= r_err_ovf | w_set_ovf;
      r_err_unf <= r_err_unf | w_set_unf;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_depth_next = r_depth;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_fetch_en   = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    unique case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        w_fetch_en = !stall;
        if (!stall) begin
          // Stack errors freeze pc where the faulting instruction sits.
          if (ret) begin
            if (r_depth != '0) begin
              w_pop        = 1'b1;
              w_pc_next    = stack_out;
              w_depth_next = r_depth - DW'(1);
            end else begin
              w_set_unf    = 1'b1;
              w_state_next = HALT;
            end
          end else if (call) begin
            if (r_depth != DEPTH_FULL) begin
              w_push       = 1'b1;
              w_pc_next    = target;
              w_depth_next = r_depth + DW'(1);
            end else begin
              w_set_ovf    = 1'b1;
              w_state_next = HALT;
            end
          end else if (jump) begin
            w_pc_next = target;
          end else if (skip) begin
            w_pc_next = r_pc + PC_W'(2);
          end else begin
            w_pc_next = r_pc + PC_W'(1);
          end
        end
      end
      HALT: w_state_next = HALT;
      default: w_state_next = BOOT;
    endcase
  end

  // Gating with reset keeps the strobes low while reset is held low.
  assign push     = w_push & reset;
  assign pop      = w_pop & reset;
  assign fetch_en = w_fetch_en & reset;
  assign stack_in = r_pc + PC_W'(1);
  assign pc       = r_pc;
  assign depth    = r_depth;
  assign halted   = r_halted;
  assign err_ovf  = r_err_ovf;
  assign err_unf  = r_err_unf;

endmodule : pc_sequencer

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 11, program-counter and return-address width.
REQ-002 SHALL have parameter STK_DEPTH, default 16, return-stack capacity in entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  freeze the sequencer this cycle.
REQ-006 SHALL have port jump  input  1  unconditional branch to target.
REQ-007 SHALL have port call  input  1  subroutine call to target; push the return address.
REQ-008 SHALL have port ret  input  1  return; pop the address from the stack.
REQ-009 SHALL have port skip  input  1  skip the next instruction.
REQ-010 SHALL have port target  input  PC_W  branch or call destination.
REQ-011 SHALL have port stack_out  input  PC_W  top-of-stack value from the return stack, combinational.
REQ-012 SHALL have port pc  output  PC_W  current fetch address, registered.
REQ-013 SHALL have port fetch_en  output  1  the instruction at pc is valid to fetch this cycle.
REQ-014 SHALL have port push  output  1  return-stack push strobe, combinational.
REQ-015 SHALL have port pop  output  1  return-stack pop strobe, combinational.
REQ-016 SHALL have port stack_in  output  PC_W  return address to push, combinational.
REQ-017 SHALL have port depth  output  $clog2(STK_DEPTH)+1  current number of stack entries.
REQ-018 SHALL have port halted  output  1  sticky stack-error halt indicator.
REQ-019 SHALL have port err_ovf  output  1  sticky flag: call issued with the stack full.
REQ-020 SHALL have port err_unf  output  1  sticky flag: ret issued with the stack empty.

Function
REQ-021 SHALL implement a three-state FSM: BOOT, RUN and HALT.
REQ-022 BOOT SHALL last exactly one cycle after reset deassertion, with fetch_en=0 and push=pop=0, then go to RUN.
REQ-023 In RUN, a command SHALL be considered "active" when the FSM is in RUN and stall is 0.
REQ-024 In RUN, fetch_en SHALL equal !stall.
REQ-025 Commands SHALL resolve in this fixed priority: stall > ret > call > jump > skip > sequential increment; lower-priority inputs are ignored.
REQ-026 Stall SHALL hold pc, depth, push=0 and pop=0.
REQ-027 Ret with depth>0 SHALL assert pop in the same cycle; pc<=stack_out; depth decrements by 1.
REQ-028 Call with depth<STK_DEPTH SHALL assert push in the same cycle with stack_in=pc+1; pc<=target; depth increments by 1.
REQ-029 Jump SHALL set pc<=target.
REQ-030 Skip SHALL set pc<=pc+2.
REQ-031 With no command, pc SHALL advance to pc<=pc+1.
REQ-032 All pc arithmetic SHALL wrap modulo 2^PC_W (e.g. 0x7FF+1=0x000, 0x7FF+2=0x001); stack_in for a call at 0x7FF SHALL be 0x000.
REQ-033 Call with depth==STK_DEPTH SHALL NOT push, SHALL set err_ovf, and the FSM SHALL enter HALT; pc is unchanged.
REQ-034 Ret with depth==0 SHALL NOT pop, SHALL set err_unf, and the FSM SHALL enter HALT; pc is unchanged.
REQ-035 In HALT: pc and depth SHALL be held, fetch_en=push=pop=0, halted=1; HALT SHALL be exited only by reset.
REQ-036 push and pop SHALL never both be 1 in the same cycle.
REQ-037 stack_in SHALL equal pc+1 at all times; it is qualified only by push.

Reset
REQ-038 Asserting reset (reset=0) SHALL asynchronously force: state=BOOT, pc=0, depth=0, halted=0, err_ovf=0, err_unf=0.
REQ-039 While reset is asserted, push, pop and fetch_en SHALL be 0.
REQ-040 Reset asserted mid-call or mid-ret SHALL abort the operation with no push or pop committed after the asynchronous assertion.

Structure
REQ-041 The state enum (BOOT/RUN/HALT) and the defaults PC_W=11 and STK_DEPTH=16 SHALL live in a shared package, pc_pkg.
REQ-042 The block SHALL be a single module with no sub-modules; it is instantiated beside the return stack at the top level.

Verification
REQ-043 Reset then run with no commands -> first cycle fetch_en=0 with pc=0x000; pc then reads 0x000, 0x001, 0x002 ... with fetch_en=1.
REQ-044 At pc=0x010, pulse call with target=0x200 -> push=1 and stack_in=0x011 that cycle; next cycle pc=0x200 and depth=1; then ret with stack_out=0x011 -> pop=1, next pc=0x011, depth=0.
REQ-045 Assert call, jump and skip together at pc=0x050 with target=0x100 -> call wins (push=1, pc=0x100); then assert stall with ret -> pc holds at 0x100 and pop=0.
REQ-046 Issue 16 nested calls, then a 17th -> the 17th has push=0, err_ovf=1, halted=1; pc frozen; the block stays halted until reset.
REQ-047 Ret at depth=0 -> pop=0, err_unf=1, halted=1; skip at pc=0x7FE -> pc=0x000; jump to target=0x7FF followed by a sequential step -> pc=0x000.
REQ-048 Assert reset asynchronously mid-cycle during a call -> pc=0 and depth=0 immediately, push drops to 0, and BOOT is re-entered.
